// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared constants and types for the programmable clock
// dividers in the clock-generation area.
//   DEFAULT_W       default counter/divisor width for sibling dividers
//   DEFAULT_DIV_VAL divisor in effect after reset
//   DIV_MIN         smallest divisor accepted by a load
//   div_mode_e      per-edge operating mode of the divider state machine
package clock_div_pkg;

    localparam int DEFAULT_W       = 8;
    localparam int DEFAULT_DIV_VAL = 32;
    localparam int DIV_MIN         = 2;

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'd0,  // synchronous restart of the current period
        MODE_IDLE  = 2'd1,  // enable low: frozen, pending divisor applies at once
        MODE_COUNT = 2'd2   // enable high: normal counting
    } div_mode_e;

endpackage

// File: rtl/clock_div_prog.sv
// clock_div_prog: runtime-programmable integer clock divider.
// Divides clk_in by N in [2, 2^W-1]; clk_div is low for floor(N/2) cycles and
// high for ceil(N/2) cycles; tick marks the last cycle of every period.
// A new divisor is held in a shadow register and only takes effect at a period
// boundary (wrap, sync_clr, or while idle), so periods are never cut short.
// Handshake: div_load is a single-cycle strobe sampled on the rising edge of
// clk_in together with div_in; there is no back-pressure, a later strobe
// overwrites an earlier one that has not reached a boundary yet.
// Ports:
//   clk_in      in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   count enable (0 freezes the divider)
//   sync_clr    in   synchronous restart, has priority over en
//   div_in      in   [W-1:0] new divisor value
//   div_load    in   one-cycle strobe capturing div_in
//   clk_div     out  registered divided clock
//   tick        out  one-cycle pulse in the last cycle of each period
//   div_active  out  [W-1:0] divisor currently in effect
//   div_pending out  a loaded divisor is waiting for a boundary
//   load_err    out  one-cycle pulse after a rejected load (div_in < 2)
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic         sync_clr,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
    output logic         clk_div,
    output logic         tick,
    output logic [W-1:0] div_active,
    output logic         div_pending,
    output logic         load_err
);

    localparam logic [W-1:0] RST_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_DIV = W'(DIV_MIN);

    logic [W-1:0] cnt;
    logic [W-1:0] shadow;

    logic [W-1:0] cnt_nx;
    logic [W-1:0] active_nx;
    logic [W-1:0] shadow_nx;
    logic         pending_nx;
    logic         clk_div_nx;
    logic         tick_nx;
    logic         load_err_nx;
    logic         load_ok;
    logic         apply;
    div_mode_e    mode;

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            div_active  <= RST_DIV;
            shadow      <= RST_DIV;
            div_pending <= 1'b0;
            clk_div     <= 1'b0;
            tick        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            div_active  <= active_nx;
            shadow      <= shadow_nx;
            div_pending <= pending_nx;
            clk_div     <= clk_div_nx;
            tick        <= tick_nx;
            load_err    <= load_err_nx;
        end
    end

    // Next-state and output logic
    always_comb begin
        mode        = sync_clr ? MODE_CLEAR : (en ? MODE_COUNT : MODE_IDLE);
        load_ok     = div_load && (div_in >= MIN_DIV);
        load_err_nx = div_load && !load_ok;
        cnt_nx      = cnt;
        active_nx   = div_active;
        shadow_nx   = load_ok ? div_in : shadow;
        pending_nx  = div_pending || load_ok;
        apply       = 1'b0;

        case (mode)
            MODE_CLEAR: begin
                apply  = 1'b1;
                cnt_nx = '0;
            end
            MODE_IDLE: begin
                // Idle is always a boundary, but only restarts the period
                // when there is actually a divisor to switch to.
                apply = div_pending || load_ok;
                if (apply) cnt_nx = '0;
            end
            default: begin
                if (cnt == div_active - 1'b1) begin
                    apply  = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        endcase

        // A strobe landing on a boundary edge wins over an older shadow value.
        if (apply) begin
            pending_nx = 1'b0;
            if (load_ok)          active_nx = div_in;
            else if (div_pending) active_nx = shadow;
        end

        // Outputs are computed from the next count so they line up with cnt.
        if (mode == MODE_IDLE && !apply) clk_div_nx = clk_div;
        else                             clk_div_nx = (cnt_nx >= (active_nx >> 1));
        tick_nx = (mode == MODE_COUNT) && (cnt_nx == active_nx - 1'b1);
    end

endmodule

// File: tb/tb_clock_div_prog.sv
module tb_clock_div_prog;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         en;
    logic         sync_clr;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_div;
    logic         tick;
    logic [W-1:0] div_active;
    logic         div_pending;
    logic         load_err;

    int n_pass  = 0;
    int n_total = 0;

    // Clock / reset
    always #5 clk_in = ~clk_in;

    clock_div_prog #(.W(W), .DEFAULT_DIV(32)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .sync_clr    (sync_clr),
        .div_in      (div_in),
        .div_load    (div_load),
        .clk_div     (clk_div),
        .tick        (tick),
        .div_active  (div_active),
        .div_pending (div_pending),
        .load_err    (load_err)
    );

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        sync_clr = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        #2;
        check("rst_clk_div", 32'(clk_div), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_div_active", 32'(div_active), 32);
        check("rst_div_pending", 32'(div_pending), 0);
        check("rst_load_err", 32'(load_err), 0);
        steps(2);
        rst = 1'b0;
        en  = 1'b1;

        // 1: default divide-by-32, two periods
        for (int c = 0; c < 64; c++) begin
            check("t1_clk_div", 32'(clk_div), ((c % 32) >= 16) ? 1 : 0);
            check("t1_tick", 32'(tick), ((c % 32) == 31) ? 1 : 0);
            step();
        end
        check("t1_div_active", 32'(div_active), 32);

        // 2: load 5 at cycle 10, applies at the wrap
        steps(10);
        div_load = 1'b1;
        div_in   = 8'd5;
        step();
        div_load = 1'b0;
        check("t2_pending_set", 32'(div_pending), 1);
        check("t2_active_held", 32'(div_active), 32);
        steps(20);
        check("t2_last_tick", 32'(tick), 1);
        check("t2_pending_before_wrap", 32'(div_pending), 1);
        check("t2_clk_high_before_wrap", 32'(clk_div), 1);
        step();
        check("t2_active_applied", 32'(div_active), 5);
        check("t2_pending_clear", 32'(div_pending), 0);
        for (int c = 0; c < 10; c++) begin
            check("t2_clk_div", 32'(clk_div), ((c % 5) >= 2) ? 1 : 0);
            check("t2_tick", 32'(tick), ((c % 5) == 4) ? 1 : 0);
            step();
        end

        // 3: freeze at cnt=2 (clk_div high), then idle load of 3
        steps(2);
        en = 1'b0;
        step();
        check("t3_freeze_clk", 32'(clk_div), 1);
        check("t3_freeze_tick", 32'(tick), 0);
        step();
        check("t3_freeze_clk2", 32'(clk_div), 1);
        div_load = 1'b1;
        div_in   = 8'd3;
        step();
        div_load = 1'b0;
        check("t3_idle_clk", 32'(clk_div), 0);
        check("t3_idle_active", 32'(div_active), 3);
        check("t3_idle_pending", 32'(div_pending), 0);
        en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("t3_clk_div", 32'(clk_div), ((c % 3) >= 1) ? 1 : 0);
            check("t3_tick", 32'(tick), ((c % 3) == 2) ? 1 : 0);
            step();
        end

        // 4: rejected loads of 1 and 0
        div_load = 1'b1;
        div_in   = 8'd1;
        step();
        div_load = 1'b0;
        check("t4_err_1", 32'(load_err), 1);
        check("t4_pending_1", 32'(div_pending), 0);
        step();
        check("t4_err_1_clear", 32'(load_err), 0);
        div_load = 1'b1;
        div_in   = 8'd0;
        step();
        div_load = 1'b0;
        check("t4_err_0", 32'(load_err), 1);
        step();
        check("t4_err_0_clear", 32'(load_err), 0);
        check("t4_active", 32'(div_active), 3);
        check("t4_pending", 32'(div_pending), 0);

        // 5a: realign with sync_clr, then load 4 then 6 in one period
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("t5_clr_clk", 32'(clk_div), 0);
        check("t5_clr_tick", 32'(tick), 0);
        div_load = 1'b1;
        div_in   = 8'd4;
        step();
        div_in   = 8'd6;
        step();
        div_load = 1'b0;
        check("t5_pending", 32'(div_pending), 1);
        check("t5_active_old", 32'(div_active), 3);
        check("t5_tick_old_period", 32'(tick), 1);
        step();
        check("t5_last_wins", 32'(div_active), 6);
        check("t5_pending_clear", 32'(div_pending), 0);
        // 5b: load 9 exactly on the wrap edge of the 6-period
        steps(5);
        check("t5_tick6", 32'(tick), 1);
        div_load = 1'b1;
        div_in   = 8'd9;
        step();
        div_load = 1'b0;
        check("t5_wrap_load_active", 32'(div_active), 9);
        check("t5_wrap_load_pending", 32'(div_pending), 0);
        for (int c = 0; c < 9; c++) begin
            check("t5_clk_div", 32'(clk_div), (c >= 4) ? 1 : 0);
            check("t5_tick", 32'(tick), (c == 8) ? 1 : 0);
            step();
        end

        // 6a: asynchronous reset in the high phase with a load pending
        steps(6);
        div_load = 1'b1;
        div_in   = 8'd7;
        step();
        div_load = 1'b0;
        check("t6_pre_clk", 32'(clk_div), 1);
        check("t6_pre_pending", 32'(div_pending), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_clk", 32'(clk_div), 0);
        check("t6_async_tick", 32'(tick), 0);
        check("t6_async_active", 32'(div_active), 32);
        check("t6_async_pending", 32'(div_pending), 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("t6_post_clk", 32'(clk_div), (c >= 16) ? 1 : 0);
            check("t6_post_tick", 32'(tick), 0);
            step();
        end

        // 6b: sync_clr mid-period applies the pending divisor
        div_load = 1'b1;
        div_in   = 8'd10;
        step();
        div_load = 1'b0;
        steps(2);
        check("t6_clr_pre_pending", 32'(div_pending), 1);
        check("t6_clr_pre_clk", 32'(clk_div), 1);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("t6_clr_active", 32'(div_active), 10);
        check("t6_clr_pending", 32'(div_pending), 0);
        for (int c = 0; c < 10; c++) begin
            check("t6_clr_clk", 32'(clk_div), (c >= 5) ? 1 : 0);
            check("t6_clr_tick", 32'(tick), (c == 9) ? 1 : 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
